// File: rtl/decoder_pipe_if.sv
// rtl/decoder_pipe_if.sv - ID/EX decode stage handshake and result bus
interface decoder_pipe_if #(
  parameter int EXEC_BUS_WIDTH = 7,
  parameter int MEM_BUS_WIDTH  = 3,
  parameter int WB_BUS_WIDTH   = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               instr;
  logic                      flush;
  logic                      out_ready;
  logic                      out_valid;
  logic [EXEC_BUS_WIDTH-1:0] execute_bus;
  logic [MEM_BUS_WIDTH-1:0]  memory_bus;
  logic [WB_BUS_WIDTH-1:0]   wb_bus;
  logic [4:0]                out_rs;
  logic [4:0]                out_rt;
  logic [4:0]                out_rd;
  logic [31:0]               out_imm;
  logic                      hazard_stall;
  logic                      illegal;

  // Fetch/execute side: supplies instructions and accepts decoded results
  modport master (
    output in_valid, instr, flush, out_ready,
    input  in_ready, out_valid, execute_bus, memory_bus, wb_bus,
    input  out_rs, out_rt, out_rd, out_imm, hazard_stall, illegal
  );

  // Decode stage side
  modport slave (
    input  in_valid, instr, flush, out_ready,
    output in_ready, out_valid, execute_bus, memory_bus, wb_bus,
    output out_rs, out_rt, out_rd, out_imm, hazard_stall, illegal
  );
endinterface

// File: rtl/decoder_pipe.sv
// rtl/decoder_pipe.sv - registered MIPS ID/EX decode stage with load-use bubble insertion
module decoder_pipe #(
  parameter int EXEC_BUS_WIDTH   = 7,
  parameter int MEM_BUS_WIDTH    = 3,
  parameter int WB_BUS_WIDTH     = 2,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input logic           clk,
  input logic           rst_n,
  decoder_pipe_if.slave bus
);

  localparam logic [3:0] ALU_SLL  = 4'b0000;
  localparam logic [3:0] ALU_SRL  = 4'b0001;
  localparam logic [3:0] ALU_SRA  = 4'b0010;
  localparam logic [3:0] ALU_ADDU = 4'b0011;
  localparam logic [3:0] ALU_AND  = 4'b0100;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SUBU = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1010;
  localparam logic [3:0] ALU_NONE = 4'b1111;

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  logic                      valid_q;
  logic [EXEC_BUS_WIDTH-1:0] ex_q;
  logic [MEM_BUS_WIDTH-1:0]  mem_q;
  logic [WB_BUS_WIDTH-1:0]   wb_q;
  logic [4:0]                rs_q, rt_q, rd_q;
  logic [31:0]               imm_q;
  logic                      ill_q;

  logic [EXEC_BUS_WIDTH-1:0] ex_d;
  logic [MEM_BUS_WIDTH-1:0]  mem_d;
  logic [WB_BUS_WIDTH-1:0]   wb_d;
  logic [31:0]               imm_d;
  logic                      ill_d;
  logic                      uses_rt;

  logic       load_en, hazard, in_ready, hazard_stall;
  logic [5:0] op, fn;
  logic [4:0] rs_in, rt_in;

  assign op    = bus.instr[31:26];
  assign fn    = bus.instr[5:0];
  assign rs_in = bus.instr[25:21];
  assign rt_in = bus.instr[20:16];

  // An empty output slot can always be refilled, even while execute stalls
  assign load_en = bus.out_ready || !valid_q;

  // Held load whose destination is read by the incoming instruction
  assign hazard = (state_q == RUN) && valid_q && mem_q[1] && (rt_q != 5'd0) && bus.in_valid &&
                  ((rt_q == rs_in) || (uses_rt && (rt_q == rt_in)));

  // Instruction decode into control buses, immediate and illegal flag
  always_comb begin
    logic [3:0] alu;
    logic       alu_src, reg_dst, shamt_flag;
    logic       mem_write, mem_read, branch_flag, mem_to_reg, reg_write, zext;
    alu = ALU_NONE; alu_src = 1'b0; reg_dst = 1'b0; shamt_flag = 1'b0;
    mem_write = 1'b0; mem_read = 1'b0; branch_flag = 1'b0;
    mem_to_reg = 1'b0; reg_write = 1'b0; zext = 1'b0;
    ill_d = 1'b0; uses_rt = 1'b0;
    case (op)
      6'b000000: begin
        uses_rt = 1'b1; reg_dst = 1'b1; reg_write = 1'b1;
        case (fn)
          6'b000000: begin alu = ALU_SLL; shamt_flag = 1'b1; end
          6'b000010: begin alu = ALU_SRL; shamt_flag = 1'b1; end
          6'b000011: begin alu = ALU_SRA; shamt_flag = 1'b1; end
          6'b000100: alu = ALU_SLL;
          6'b000110: alu = ALU_SRL;
          6'b000111: alu = ALU_SRA;
          6'b100001: alu = ALU_ADDU;
          6'b100011: alu = ALU_SUBU;
          6'b100100: alu = ALU_AND;
          6'b100101: alu = ALU_OR;
          6'b100110: alu = ALU_XOR;
          6'b100111: alu = ALU_NOR;
          6'b101010: alu = ALU_SLT;
          6'b001000: begin branch_flag = 1'b1; reg_write = 1'b0; end
          6'b001001: branch_flag = 1'b1;
          default: begin alu = 4'b0000; reg_dst = 1'b0; reg_write = 1'b0; ill_d = 1'b1; end
        endcase
        // The all-zero word is the canonical NOP: an SLL that writes nothing
        if (bus.instr == 32'h0) reg_write = 1'b0;
      end
      6'b000100, 6'b000101: begin alu = ALU_SUBU; branch_flag = 1'b1; uses_rt = 1'b1; end
      6'b000010: branch_flag = 1'b1;
      6'b000011: begin branch_flag = 1'b1; reg_write = 1'b1; end
      6'b001000: begin alu = ALU_ADDU; alu_src = 1'b1; reg_write = 1'b1; end
      6'b001010: begin alu = ALU_SLT;  alu_src = 1'b1; reg_write = 1'b1; end
      6'b001100: begin alu = ALU_AND;  alu_src = 1'b1; reg_write = 1'b1; zext = 1'b1; end
      6'b001101: begin alu = ALU_OR;   alu_src = 1'b1; reg_write = 1'b1; zext = 1'b1; end
      6'b001110: begin alu = ALU_XOR;  alu_src = 1'b1; reg_write = 1'b1; zext = 1'b1; end
      6'b001111: begin alu = ALU_LUI;  alu_src = 1'b1; reg_write = 1'b1; end
      default: begin
        if (op[5:3] == 3'b100) begin
          alu = ALU_ADDU; alu_src = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; reg_write = 1'b1;
        end else if (op[5:3] == 3'b101) begin
          alu = ALU_ADDU; alu_src = 1'b1; mem_write = 1'b1; uses_rt = 1'b1;
        end else begin
          alu = 4'b0000; ill_d = 1'b1;
        end
      end
    endcase
    ex_d = '0;
    ex_d[3:0] = alu;
    ex_d[4]   = alu_src;
    ex_d[5]   = reg_dst;
    ex_d[6]   = shamt_flag;
    mem_d = '0;
    mem_d[0] = mem_write;
    mem_d[1] = mem_read;
    mem_d[2] = branch_flag;
    wb_d = '0;
    wb_d[0] = mem_to_reg;
    wb_d[1] = reg_write;
    imm_d = zext ? {16'h0, bus.instr[15:0]} : {{16{bus.instr[15]}}, bus.instr[15:0]};
  end

  // FSM state and bubble counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM next state: enter BUBBLE on a load-use hazard, count bubbles out, flush wins
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = RUN;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (hazard && load_en) begin
            state_d = BUBBLE;
            cnt_d   = 3'(LOAD_USE_BUBBLES - 1);
          end
        end
        BUBBLE: begin
          if (load_en) begin
            if (cnt_q == 3'd0) state_d = RUN;
            else               cnt_d   = cnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // FSM outputs: upstream handshake and PC/IF-ID hold
  always_comb begin
    in_ready     = load_en && (state_q == RUN) && !hazard && !bus.flush;
    hazard_stall = (state_q == BUBBLE);
  end

  // ID/EX pipeline register: load on accept, insert bubble otherwise, hold under backpressure
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
      imm_q   <= 32'h0;
      ill_q   <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      ill_q   <= 1'b0;
    end else if (load_en) begin
      if (bus.in_valid && in_ready) begin
        valid_q <= 1'b1;
        ex_q    <= ex_d;
        mem_q   <= mem_d;
        wb_q    <= wb_d;
        rs_q    <= rs_in;
        rt_q    <= rt_in;
        rd_q    <= bus.instr[15:11];
        imm_q   <= imm_d;
        ill_q   <= ill_d;
      end else begin
        valid_q <= 1'b0;
        ill_q   <= 1'b0;
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.hazard_stall = hazard_stall;
  assign bus.out_valid    = valid_q;
  assign bus.execute_bus  = ex_q;
  assign bus.memory_bus   = mem_q;
  assign bus.wb_bus       = wb_q;
  assign bus.out_rs       = rs_q;
  assign bus.out_rt       = rt_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_imm      = imm_q;
  assign bus.illegal      = ill_q;

endmodule

// File: tb/tb_decoder_pipe.sv
// tb/tb_decoder_pipe.sv - randomized check of decoder_pipe against a behavioural model
module tb_decoder_pipe;

  localparam int NB = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  decoder_pipe_if #(.EXEC_BUS_WIDTH(7), .MEM_BUS_WIDTH(3), .WB_BUS_WIDTH(2)) bus ();

  decoder_pipe #(
    .EXEC_BUS_WIDTH(7), .MEM_BUS_WIDTH(3), .WB_BUS_WIDTH(2), .LOAD_USE_BUBBLES(NB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Model of the ID/EX register contents and remaining bubble cycles
  bit          m_v;
  logic [6:0]  m_ex;
  logic [2:0]  m_me;
  logic [1:0]  m_wb;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_imm;
  bit          m_ill;
  int          m_stall;
  bit          got_ir, got_hs;

  // Compare and tally
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_v = 0; m_ex = '0; m_me = '0; m_wb = '0; m_rs = '0; m_rt = '0; m_rd = '0;
    m_imm = '0; m_ill = 0; m_stall = 0;
  endtask

  // Reference decode written from the instruction-class tables
  function automatic void ref_dec(input logic [31:0] w, output logic [6:0] ex, output logic [2:0] me,
                                  output logic [1:0] wb, output bit ill, output bit urt,
                                  output logic [31:0] imm);
    logic [5:0] op, fn;
    logic [3:0] alu;
    bit src, dst, sh, mw, mr, br, m2r, rw;
    op = w[31:26]; fn = w[5:0];
    alu = 4'hF; src = 0; dst = 0; sh = 0; mw = 0; mr = 0; br = 0; m2r = 0; rw = 0;
    ill = 0; urt = 0;
    if (op == 6'd0) begin
      urt = 1; dst = 1; rw = (w != 32'h0);
      if (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07}) begin
        alu = (fn[1:0] == 2'b00) ? 4'd0 : (fn[1:0] == 2'b10) ? 4'd1 : 4'd2;
        sh  = !fn[2];
      end else if (fn == 6'h21) alu = 4'd3;
      else if (fn == 6'h23) alu = 4'd8;
      else if (fn == 6'h24) alu = 4'd4;
      else if (fn == 6'h25) alu = 4'd5;
      else if (fn == 6'h26) alu = 4'd6;
      else if (fn == 6'h27) alu = 4'd7;
      else if (fn == 6'h2A) alu = 4'd9;
      else if (fn == 6'h08) begin br = 1; rw = 0; end
      else if (fn == 6'h09) br = 1;
      else begin alu = 4'd0; dst = 0; rw = 0; ill = 1; end
    end else if (op == 6'h04 || op == 6'h05) begin
      alu = 4'd8; br = 1; urt = 1;
    end else if (op == 6'h02 || op == 6'h03) begin
      br = 1; rw = (op == 6'h03);
    end else if (op inside {6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F}) begin
      src = 1; rw = 1;
      case (op)
        6'h08: alu = 4'd3;
        6'h0A: alu = 4'd9;
        6'h0C: alu = 4'd4;
        6'h0D: alu = 4'd5;
        6'h0E: alu = 4'd6;
        default: alu = 4'd10;
      endcase
    end else if (op[5:3] == 3'b100) begin
      alu = 4'd3; src = 1; mr = 1; m2r = 1; rw = 1;
    end else if (op[5:3] == 3'b101) begin
      alu = 4'd3; src = 1; mw = 1; urt = 1;
    end else begin
      alu = 4'd0; ill = 1;
    end
    ex  = {sh, dst, src, alu};
    me  = {br, mr, mw};
    wb  = {rw, m2r};
    imm = (op inside {6'h0C, 6'h0D, 6'h0E}) ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
  endfunction

  task automatic check_regs();
    check("out_valid",   32'(bus.out_valid),   32'(m_v));
    check("execute_bus", 32'(bus.execute_bus), 32'(m_ex));
    check("memory_bus",  32'(bus.memory_bus),  32'(m_me));
    check("wb_bus",      32'(bus.wb_bus),      32'(m_wb));
    check("out_rs",      32'(bus.out_rs),      32'(m_rs));
    check("out_rt",      32'(bus.out_rt),      32'(m_rt));
    check("out_rd",      32'(bus.out_rd),      32'(m_rd));
    check("out_imm",     bus.out_imm,          m_imm);
    check("illegal",     32'(bus.illegal),     32'(m_ill));
  endtask

  // One clock: drive, check at the falling edge, advance the model, return just after the rising edge
  task automatic step(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl);
    logic [6:0] ex; logic [2:0] me; logic [1:0] wb; logic [31:0] imm;
    bit ill, urt, le, haz, exp_ir;
    bus.in_valid = iv; bus.instr = ins; bus.out_ready = ordy; bus.flush = fl;
    @(negedge clk);
    check_regs();
    ref_dec(ins, ex, me, wb, ill, urt, imm);
    le  = ordy || !m_v;
    haz = (m_stall == 0) && m_v && m_me[1] && (m_rt != 0) && iv &&
          ((m_rt == ins[25:21]) || (urt && m_rt == ins[20:16]));
    exp_ir = le && (m_stall == 0) && !haz && !fl;
    got_ir = bus.in_ready;
    got_hs = bus.hazard_stall;
    check("in_ready",     32'(bus.in_ready),     32'(exp_ir));
    check("hazard_stall", 32'(bus.hazard_stall), 32'(m_stall != 0));
    if (fl) begin
      m_v = 0; m_ex = '0; m_me = '0; m_wb = '0; m_ill = 0; m_stall = 0;
    end else if (m_stall != 0) begin
      if (le) begin m_v = 0; m_ill = 0; m_stall--; end
    end else if (haz) begin
      if (le) begin m_v = 0; m_ill = 0; m_stall = NB; end
    end else if (le) begin
      if (iv) begin
        m_v = 1; m_ex = ex; m_me = me; m_wb = wb; m_ill = ill; m_imm = imm;
        m_rs = ins[25:21]; m_rt = ins[20:16]; m_rd = ins[15:11];
      end else begin
        m_v = 0; m_ill = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op, fn;
    logic [5:0] fns [18] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h21, 6'h23, 6'h24,
                             6'h25, 6'h26, 6'h27, 6'h2A, 6'h08, 6'h09, 6'h01, 6'h3F, 6'h20};
    logic [5:0] imms [6] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h0F};
    logic [5:0] brs [4] = '{6'h04, 6'h05, 6'h02, 6'h03};
    logic [4:0] rs, rt;
    logic [15:0] lo;
    rs = 5'($urandom_range(0, 3));
    rt = 5'($urandom_range(0, 3));
    lo = 16'($urandom);
    fn = lo[5:0];
    case ($urandom_range(0, 9))
      0, 1, 2: begin op = 6'h00; fn = fns[$urandom_range(0, 17)]; end
      3: op = 6'(6'h20 + $urandom_range(0, 7));
      4: op = 6'(6'h28 + $urandom_range(0, 7));
      5: op = brs[$urandom_range(0, 3)];
      6, 7: op = imms[$urandom_range(0, 5)];
      8: op = 6'($urandom);
      default: return 32'h0;
    endcase
    return {op, rs, rt, lo[15:6], fn};
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 0; bus.instr = '0; bus.flush = 0; bus.out_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs();
    check("reset hazard_stall", 32'(bus.hazard_stall), 32'd0);
    rst_n = 1'b1;

    // ADDU $3,$1,$2
    step(1, 32'h00221821, 1, 0);
    check("addu execute_bus", 32'(bus.execute_bus), 32'h23);
    check("addu wb_bus",      32'(bus.wb_bus),      32'h2);
    check("addu out_rd",      32'(bus.out_rd),      32'd3);
    check("addu out_valid",   32'(bus.out_valid),   32'd1);

    // LW $2,4($1) then dependent ADDU $3,$2,$4
    step(1, 32'h8C220004, 1, 0);
    step(1, 32'h00441821, 1, 0);
    check("lu in_ready", 32'(got_ir), 32'd0);
    for (int i = 0; i < NB; i++) begin
      step(1, 32'h00441821, 1, 0);
      check("lu stall", 32'(got_hs), 32'd1);
      check("lu bubble valid", 32'(bus.out_valid), 32'd0);
    end
    step(1, 32'h00441821, 1, 0);
    check("lu issue in_ready", 32'(got_ir), 32'd1);
    check("lu issue rd", 32'(bus.out_rd), 32'd3);

    // Async reset in the middle of a bubble
    step(1, 32'h8C220004, 1, 0);
    step(1, 32'h00441821, 1, 0);
    check("pre-reset stall", 32'(bus.hazard_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    check("reset mid-bubble stall", 32'(bus.hazard_stall), 32'd0);
    #1 rst_n = 1'b1;
    step(1, 32'h00221821, 1, 0);
    check("post-reset accept", 32'(got_ir), 32'd1);

    // Flush with a load held and a hazard pending
    step(1, 32'h8C220004, 1, 0);
    step(1, 32'h00441821, 1, 1);
    check("flush in_ready", 32'(got_ir), 32'd0);
    check("flush out_valid", 32'(bus.out_valid), 32'd0);
    check("flush stall", 32'(bus.hazard_stall), 32'd0);
    step(1, 32'h00441821, 1, 0);
    check("post-flush accept", 32'(got_ir), 32'd1);

    // ORI $5,$1,0x8001 held under backpressure
    step(1, 32'h34258001, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h00221821, 0, 0);
      check("bp in_ready", 32'(got_ir), 32'd0);
      check("bp out_imm", bus.out_imm, 32'h00008001);
      check("bp execute_bus", 32'(bus.execute_bus), 32'h15);
    end
    step(0, 32'h0, 1, 0);

    // NOP and an unknown opcode
    step(1, 32'h0, 1, 0);
    check("nop wb_bus", 32'(bus.wb_bus), 32'd0);
    check("nop illegal", 32'(bus.illegal), 32'd0);
    step(1, 32'hFC000000, 1, 0);
    check("bad illegal", 32'(bus.illegal), 32'd1);
    check("bad memory_bus", 32'(bus.memory_bus), 32'd0);
    check("bad wb_bus", 32'(bus.wb_bus), 32'd0);
    step(0, 32'h0, 1, 0);
    check("illegal pulse end", 32'(bus.illegal), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);
    end
    step(0, 32'h0, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
